// File: rtl/phase_rx_pkg.sv
// Shared constants and helpers for the two-phase bundled-data receiver.
// The optional transfer counter (PHASE_RX_XFER_CNT_EN) uses XFER_CNT_W.
package phase_rx_pkg;

    localparam int DEF_WIDTH       = 8;
    localparam int DEF_DEPTH       = 4;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int XFER_CNT_W      = 16;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/phase_sync.sv
// Multi-flop synchronizer bringing the asynchronous request phase into clk.
module phase_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] r_chain;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[STAGES-2:0], d};
        end
    end

    assign q = r_chain[STAGES-1];

endmodule

// File: rtl/phase_rx.sv
// Two-phase request/acknowledge receiver feeding a small valid/ready FIFO.
// Define PHASE_RX_XFER_CNT_EN to add the 16-bit xfer_cnt capture counter.
module phase_rx
    import phase_rx_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int DEPTH       = DEF_DEPTH,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_i,
    input  logic [WIDTH-1:0]      data_i,
    output logic                  ack_o,
    output logic [WIDTH-1:0]      m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [clog2(DEPTH):0] level
`ifdef PHASE_RX_XFER_CNT_EN
    ,
    output logic [XFER_CNT_W-1:0] xfer_cnt
`endif
);

    localparam int AW = clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [LW-1:0]    r_level;
    logic             r_rx_phase;
    logic             r_ack;

    logic w_req_sync;
    logic w_pending;
    logic w_pop;
    logic w_space;
    logic w_push;

    phase_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (req_i),
        .q   (w_req_sync)
    );

    // A phase mismatch means the sender has toggled since our last capture.
    assign w_pending = w_req_sync ^ r_rx_phase;
    assign w_pop     = m_valid && m_ready;
    assign w_space   = (r_level < FULL_LEVEL) || w_pop;
    assign w_push    = w_pending && w_space;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_level    <= '0;
            r_rx_phase <= 1'b0;
            r_ack      <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr     <= r_wptr + 1'b1;
                r_rx_phase <= ~r_rx_phase;
                r_ack      <= ~r_rx_phase;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // NOTE: storage carries no reset; level gates its visibility, so flushing data words would only cost area.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= data_i;
        end
    end

`ifdef PHASE_RX_XFER_CNT_EN
    logic [XFER_CNT_W-1:0] r_xfer_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_xfer_cnt <= '0;
        end else if (w_push) begin
            r_xfer_cnt <= r_xfer_cnt + 1'b1;
        end
    end

    assign xfer_cnt = r_xfer_cnt;
`endif

    assign ack_o   = r_ack;
    assign m_valid = (r_level != '0);
    assign m_data  = r_mem[r_rptr];
    assign level   = r_level;

endmodule

// File: tb/tb_phase_rx.sv
// Self-checking bench for phase_rx: directed scenarios plus randomized traffic
// compared every cycle against a queue-based reference model.
module tb_phase_rx;
    import phase_rx_pkg::*;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int SYNC  = 2;
    localparam int LW    = clog2(DEPTH) + 1;

    logic             clk     = 1'b0;
    logic             rst     = 1'b1;
    logic             req_i   = 1'b0;
    logic [WIDTH-1:0] data_i  = '0;
    logic             m_ready = 1'b0;
    logic             ack_o;
    logic [WIDTH-1:0] m_data;
    logic             m_valid;
    logic [LW-1:0]    level;
`ifdef PHASE_RX_XFER_CNT_EN
    logic [XFER_CNT_W-1:0] xfer_cnt;
`endif

    phase_rx #(
        .WIDTH       (WIDTH),
        .DEPTH       (DEPTH),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req_i   (req_i),
        .data_i  (data_i),
        .ack_o   (ack_o),
        .m_data  (m_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .level   (level)
`ifdef PHASE_RX_XFER_CNT_EN
        ,
        .xfer_cnt (xfer_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Reference model: the request is seen SYNC edges late, the buffer is a queue.
    logic [WIDTH-1:0] mq[$];
    bit               sync_q[$];
    bit               mdl_phase;
    int               mdl_caps;
    bit               mdl_seen;
    bit               mdl_pending;
    bit               mdl_pop;
    bit               mdl_push;

    always @(posedge clk) begin
        if (rst) begin
            sync_q.delete();
            repeat (SYNC) sync_q.push_back(1'b0);
            mq.delete();
            mdl_phase = 1'b0;
            mdl_caps  = 0;
        end else begin
            mdl_seen    = sync_q[0];
            mdl_pending = mdl_seen ^ mdl_phase;
            mdl_pop     = (mq.size() != 0) && m_ready;
            mdl_push    = mdl_pending && ((mq.size() < DEPTH) || mdl_pop);
            if (mdl_pop) void'(mq.pop_front());
            if (mdl_push) begin
                mq.push_back(data_i);
                mdl_phase = ~mdl_phase;
                mdl_caps++;
            end
            void'(sync_q.pop_front());
            sync_q.push_back(req_i);
        end
    end

    bit chk_en      = 1'b0;
    bit rand_ready  = 1'b0;
    bit ack_prev    = 1'b0;
    int ack_toggles = 0;

    always @(negedge clk) begin
        if (chk_en) begin
            check("level", level, mq.size());
            check("m_valid", m_valid, mq.size() != 0);
            check("ack", ack_o, mdl_phase);
            if (mq.size() != 0) check("m_data", m_data, mq[0]);
`ifdef PHASE_RX_XFER_CNT_EN
            check("xfer_cnt", xfer_cnt, mdl_caps & 32'hFFFF);
`endif
            if (ack_o !== ack_prev) ack_toggles++;
            ack_prev = ack_o;
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
        if (rand_ready) m_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send(input logic [WIDTH-1:0] d);
        data_i = d;
        req_i  = ~req_i;
    endtask

    task automatic wait_ack(input int budget);
        int n;
        n = 0;
        while (ack_o !== req_i && n < budget) begin
            step();
            n++;
        end
        if (ack_o !== req_i) check("ack_timeout", 0, 1);
    endtask

    int t0;

    initial begin
        rst = 1'b1;
        step();
        chk_en = 1'b1;
        step();
        check("rst_level", level, 0);
        check("rst_valid", m_valid, 0);
        check("rst_ack", ack_o, 0);
        rst = 1'b0;

        // Single transfer latency: visible after the third edge.
        send(8'hA5);
        step();
        check("t1_valid_e1", m_valid, 0);
        step();
        check("t1_valid_e2", m_valid, 0);
        check("t1_ack_e2", ack_o, 0);
        step();
        check("t1_valid_e3", m_valid, 1);
        check("t1_data_e3", m_data, 8'hA5);
        check("t1_ack_e3", ack_o, 1);
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
        check("t1_drained", level, 0);

        // Fill to full, fifth event must stay pending.
        t0 = ack_toggles;
        for (int i = 1; i <= 4; i++) begin
            send(WIDTH'(i));
            wait_ack(20);
        end
        send(8'h05);
        repeat (8) step();
        check("full_level", level, 4);
        check("full_toggles", ack_toggles - t0, 4);
        check("full_ack_held", ack_o, !req_i);
        check("full_head", m_data, 8'h01);

        // Pop while full with a pending event: capture and pop in one edge.
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
        check("pp_level", level, 4);
        check("pp_head", m_data, 8'h02);
        check("pp_toggles", ack_toggles - t0, 5);
        check("pp_ack", ack_o, req_i);
        m_ready = 1'b1;
        for (int e = 2; e <= 5; e++) begin
            check("pp_order", m_data, e);
            step();
        end
        m_ready = 1'b0;
        check("pp_empty", level, 0);

        // Back-pressure: head must hold while the consumer stalls.
        send(8'h3C);
        wait_ack(20);
        send(8'hC3);
        wait_ack(20);
        for (int i = 0; i < 10; i++) begin
            step();
            check("bp_data", m_data, 8'h3C);
            check("bp_level", level, 2);
        end
        m_ready = 1'b1;
        repeat (2) step();
        m_ready = 1'b0;
        check("bp_empty", level, 0);

        // Reset mid-operation with the request line left high.
        send(8'h11);
        wait_ack(20);
        send(8'h22);
        wait_ack(20);
        send(8'h33);
        wait_ack(20);
        check("mr_level", level, 3);
        data_i = 8'h77;
        req_i  = 1'b1;
        rst    = 1'b1;
        step();
        rst = 1'b0;
        check("mr_rst_level", level, 0);
        check("mr_rst_valid", m_valid, 0);
        check("mr_rst_ack", ack_o, 0);
        step();
        check("mr_valid_e1", m_valid, 0);
        step();
        check("mr_valid_e2", m_valid, 0);
        step();
        check("mr_valid_e3", m_valid, 1);
        check("mr_data_e3", m_data, 8'h77);
        check("mr_ack_e3", ack_o, 1);
        check("mr_level_e3", level, 1);
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;

        // Randomized traffic against the model.
        t0 = ack_toggles;
        rand_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            repeat ($urandom_range(0, 3)) step();
            send(WIDTH'($urandom_range(0, 255)));
            wait_ack(200);
        end
        rand_ready = 1'b0;
        m_ready = 1'b1;
        for (int i = 0; i < 20 && level != 0; i++) step();
        m_ready = 1'b0;
        check("rand_empty", level, 0);
        check("rand_toggles", ack_toggles - t0, 300);

`ifdef PHASE_RX_XFER_CNT_EN
        rst = 1'b1;
        step();
        rst = 1'b0;
        ack_prev = 1'b0;
        req_i    = 1'b0;
        step();
        check("cnt_reset", xfer_cnt, 0);
        m_ready = 1'b1;
        for (int i = 0; i < 65537; i++) begin
            send(WIDTH'(i));
            wait_ack(20);
        end
        step();
        check("cnt_wrap", xfer_cnt, 1);
        m_ready = 1'b0;
`endif

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
